// File: rtl/fifo_write_arbiter.sv
// Two-producer, burst-fair arbiter for the write port of one AFIFO.
// Write-clock domain only; words are accepted and written in the same cycle.
module fifo_write_arbiter #(
  parameter int unsigned Width    = 16,
  parameter int unsigned BurstMax = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             a_valid,
  input  logic [Width-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [Width-1:0] b_data,
  output logic             b_ready,
  output logic             w,
  output logic [Width-1:0] wd,
  input  logic             wok,
  output logic [1:0]       owner
);

  // Encoding doubles as the owner code.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntA = 2'd1,
    StGntB = 2'd2
  } state_e;

  localparam logic [7:0] CntLast = 8'(BurstMax - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_b_q, last_b_d;

  logic   cur_valid, oth_valid, beat, burst_end;
  state_e same_st, other_st;

  always_comb begin
    a_ready = (state_q == StGntA) && wok;
    b_ready = (state_q == StGntB) && wok;
    w       = (a_valid && a_ready) || (b_valid && b_ready);
    owner   = state_q;
    case (state_q)
      StGntA:  wd = a_data;
      StGntB:  wd = b_data;
      default: wd = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    cur_valid = (state_q == StGntA) ? a_valid : b_valid;
    oth_valid = (state_q == StGntA) ? b_valid : a_valid;
    same_st   = (state_q == StGntA) ? StGntA : StGntB;
    other_st  = (state_q == StGntA) ? StGntB : StGntA;
    beat      = w;
    burst_end = beat && (cnt_q == CntLast);
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (a_valid && b_valid) begin
          state_d = last_b_q ? StGntA : StGntB;
        end else if (a_valid) begin
          state_d = StGntA;
        end else if (b_valid) begin
          state_d = StGntB;
        end
      end
      StGntA, StGntB: begin
        // A stalled grant (valid high, wok low) simply holds state and count.
        if (burst_end || !cur_valid) begin
          cnt_d    = '0;
          last_b_d = (state_q == StGntB);
          if (oth_valid) begin
            state_d = other_st;
          end else if (cur_valid) begin
            state_d = same_st;
          end else begin
            state_d = StIdle;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter: two instances (BurstMax 8 and 1) each checked
// every cycle against a grant/burst reference model with bench-side producers.
module tb_fifo_write_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_;
  logic         av[2], bv[2], wk[2], ar[2], br[2], ww[2];
  logic [W-1:0] ad[2], bd[2], wdo[2];
  logic [1:0]   own[2];

  fifo_write_arbiter #(.Width(W), .BurstMax(8)) u_dut8 (
    .clk(clk), .rst_(rst_),
    .a_valid(av[0]), .a_data(ad[0]), .a_ready(ar[0]),
    .b_valid(bv[0]), .b_data(bd[0]), .b_ready(br[0]),
    .w(ww[0]), .wd(wdo[0]), .wok(wk[0]), .owner(own[0])
  );

  fifo_write_arbiter #(.Width(W), .BurstMax(1)) u_dut1 (
    .clk(clk), .rst_(rst_),
    .a_valid(av[1]), .a_data(ad[1]), .a_ready(ar[1]),
    .b_valid(bv[1]), .b_data(bd[1]), .b_ready(br[1]),
    .w(ww[1]), .wd(wdo[1]), .wok(wk[1]), .owner(own[1])
  );

  int checks = 0;
  int failures = 0;

  // Reference model: owner 0/1/2, words taken in this burst, last producer served (1=A, 2=B).
  int ms[2], mcnt[2], mlast[2];
  int bmax[2] = '{8, 1};

  // Producers: index [dut][0=A,1=B]; a word is held valid until accepted.
  bit pv[2][2], acc[2][2];
  int pidx[2][2], plim[2][2], prob[2][2], pbase[2][2];
  int wmode;
  bit tog;
  int wseen[2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; mcnt[k] = 0; mlast[k] = 2;
      acc[k][0] = 1'b0; acc[k][1] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    logic         ear, ebr, ew, cv, ov, beat, fin;
    logic [W-1:0] ewd;
    int           x;
    ear = (ms[k] == 1) && wk[k];
    ebr = (ms[k] == 2) && wk[k];
    ew  = (av[k] && ear) || (bv[k] && ebr);
    ewd = (ms[k] == 1) ? ad[k] : (ms[k] == 2) ? bd[k] : '0;
    chk("owner", k, 32'(own[k]), 32'(ms[k]));
    chk("a_ready", k, 32'(ar[k]), 32'(ear));
    chk("b_ready", k, 32'(br[k]), 32'(ebr));
    chk("w", k, 32'(ww[k]), 32'(ew));
    chk("wd", k, 32'(wdo[k]), 32'(ewd));
    chk("one_ready", k, 32'(ar[k] && br[k]), 32'd0);
    if (ww[k] === 1'b1) wseen[k]++;
    acc[k][0] = av[k] && ear;
    acc[k][1] = bv[k] && ebr;
    if (ms[k] == 0) begin
      mcnt[k] = 0;
      if (av[k] && bv[k]) ms[k] = (mlast[k] == 2) ? 1 : 2;
      else if (av[k]) ms[k] = 1;
      else if (bv[k]) ms[k] = 2;
    end else begin
      x    = ms[k];
      cv   = (x == 1) ? av[k] : bv[k];
      ov   = (x == 1) ? bv[k] : av[k];
      beat = acc[k][x-1];
      fin  = (beat && (mcnt[k] == bmax[k] - 1)) || !cv;
      if (fin) begin
        mlast[k] = x;
        mcnt[k]  = 0;
        ms[k]    = ov ? 3 - x : (cv ? x : 0);
      end else if (beat) begin
        mcnt[k]++;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc[k][p]) begin
          pidx[k][p]++;
          pv[k][p]  = 1'b0;
          acc[k][p] = 1'b0;
        end
        if (!pv[k][p] && pidx[k][p] < plim[k][p] && $urandom_range(99) < prob[k][p])
          pv[k][p] = 1'b1;
      end
      av[k] = pv[k][0];
      bv[k] = pv[k][1];
      ad[k] = pv[k][0] ? 16'(pbase[k][0] + pidx[k][0]) : 16'($urandom);
      bd[k] = pv[k][1] ? 16'(pbase[k][1] + pidx[k][1]) : 16'($urandom);
      wk[k] = (wmode < 0) ? tog : ($urandom_range(99) < wmode);
    end
    tog = ~tog;
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic phase(input string tag, input int al, input int bl, input int ap, input int bp,
                       input int abase, input int bbase, input int wm, input int n);
    for (int k = 0; k < 2; k++) begin
      plim[k][0] = al; plim[k][1] = bl;
      prob[k][0] = ap; prob[k][1] = bp;
      pbase[k][0] = abase; pbase[k][1] = bbase;
      pidx[k][0] = 0; pidx[k][1] = 0;
      pv[k][0] = 1'b0; pv[k][1] = 1'b0;
      wseen[k] = 0;
    end
    wmode = wm;
    drive();
    for (int i = 0; i < n; i++) cycle();
    for (int k = 0; k < 2; k++) chk({tag, "_words"}, k, 32'(wseen[k]), 32'(al + bl));
  endtask

  initial begin
    rst_ = 1'b0;
    tog  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      av[k] = 1'b0; bv[k] = 1'b0; wk[k] = 1'b0; ad[k] = '0; bd[k] = '0;
      for (int p = 0; p < 2; p++) begin
        pv[k][p] = 1'b0; pidx[k][p] = 0; plim[k][p] = 0; prob[k][p] = 0; pbase[k][p] = 0;
      end
    end
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_owner", k, 32'(own[k]), 32'd0);
      chk("rst_a_ready", k, 32'(ar[k]), 32'd0);
      chk("rst_b_ready", k, 32'(br[k]), 32'd0);
      chk("rst_w", k, 32'(ww[k]), 32'd0);
      chk("rst_wd", k, 32'(wdo[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_ = 1'b1;

    phase("a_only", 20, 0, 100, 0, 'h0001, 'hB000, 100, 40);
    phase("both", 32, 32, 100, 100, 'hA000, 'hB000, 100, 90);
    phase("wok_tog", 16, 16, 100, 100, 'hA100, 'hB100, -1, 110);
    phase("a_drop", 3, 12, 100, 100, 'hA200, 'hB200, 100, 40);
    phase("random", 60, 60, 30, 30, 'h1000, 'h2000, 70, 700);

    // Asynchronous reset in the middle of a busy burst.
    for (int k = 0; k < 2; k++) begin
      plim[k][0] = 1000; plim[k][1] = 1000;
      prob[k][0] = 100; prob[k][1] = 100;
      pbase[k][0] = 'h3000; pbase[k][1] = 'h4000;
      pidx[k][0] = 0; pidx[k][1] = 0;
    end
    wmode = 100;
    for (int i = 0; i < 6; i++) cycle();
    #2;
    rst_ = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_owner", k, 32'(own[k]), 32'd0);
      chk("async_a_ready", k, 32'(ar[k]), 32'd0);
      chk("async_b_ready", k, 32'(br[k]), 32'd0);
      chk("async_w", k, 32'(ww[k]), 32'd0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b1;
    cycle();
    cycle();
    chk("first_tie_A", 0, 32'(own[0]), 32'd1);
    for (int i = 0; i < 20; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
